// File: rtl/getwork_streamer_if.sv
// Transmitter-side handshake between the getwork streamer and the serial
// word transmitter.
//   tx_word : word presented to the transmitter (streamer -> transmitter)
//   tx_send : one-cycle send strobe            (streamer -> transmitter)
//   tx_busy : transmitter busy, rises one cycle after tx_send
//                                              (transmitter -> streamer)
interface getwork_streamer_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] tx_word;
    logic                  tx_send;
    logic                  tx_busy;

    modport master (output tx_word, output tx_send, input tx_busy);
    modport slave  (input tx_word, input tx_send, output tx_busy);
endinterface

// File: rtl/getwork_streamer.sv
// getwork_streamer: serialises a multi-word getwork frame (MSB word first)
// into a word-wide transmitter using a send/busy handshake. Supports a nonce
// offset, repeated frames with the nonce stepped by the frame index, an idle
// gap between frames and abort.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   start          : begin a transfer (only honoured in IDLE)
//   payload        : frame contents, captured on accepted start
//   nonce_offset   : two's-complement offset added to the nonce word
//   repeat_count   : extra frames after the first
//   abort          : terminate the transfer, back to IDLE
//   tx             : transmitter handshake (tx_word, tx_send, tx_busy)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse after the last word of the last frame
//   frames_sent    : completed frames in the current/last transfer
module getwork_streamer #(
    parameter int WORD_WIDTH   = 32,
    parameter int NUM_WORDS    = 13,
    parameter int NONCE_INDEX  = 1,
    parameter int GAP_CYCLES   = 16,
    parameter int REPEAT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] payload,
    input  logic [WORD_WIDTH-1:0]           nonce_offset,
    input  logic [REPEAT_WIDTH-1:0]         repeat_count,
    input  logic                            abort,
    getwork_streamer_if.master              tx,
    output logic                            busy,
    output logic                            done,
    output logic [REPEAT_WIDTH:0]           frames_sent
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] NONCE_IDX = IDX_W'(NONCE_INDEX);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_ACK, S_DRAIN, S_GAP} state_t;

    state_t                          state_reg, state_next;
    logic [NUM_WORDS*WORD_WIDTH-1:0] payload_reg, payload_next;
    logic [WORD_WIDTH-1:0]           offset_reg, offset_next;
    logic [REPEAT_WIDTH-1:0]         repeat_reg, repeat_next;
    logic [IDX_W-1:0]                word_idx_reg, word_idx_next;
    logic [REPEAT_WIDTH-1:0]         frame_idx_reg, frame_idx_next;
    logic [REPEAT_WIDTH:0]           frames_sent_reg, frames_sent_next;
    logic [GAP_W-1:0]                gap_cnt_reg, gap_cnt_next;
    logic [WORD_WIDTH-1:0]           tx_word_reg, tx_word_next;
    logic                            done_reg, done_next;
    logic                            load_word;

    // Word view of the payload that will be in effect next cycle; word 0 is
    // the most significant word of the vector.
    logic [WORD_WIDTH-1:0] word_sel [NUM_WORDS];

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            assign word_sel[gi] = payload_next[(NUM_WORDS-1-gi)*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            payload_reg     <= '0;
            offset_reg      <= '0;
            repeat_reg      <= '0;
            word_idx_reg    <= '0;
            frame_idx_reg   <= '0;
            frames_sent_reg <= '0;
            gap_cnt_reg     <= '0;
            tx_word_reg     <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            payload_reg     <= payload_next;
            offset_reg      <= offset_next;
            repeat_reg      <= repeat_next;
            word_idx_reg    <= word_idx_next;
            frame_idx_reg   <= frame_idx_next;
            frames_sent_reg <= frames_sent_next;
            gap_cnt_reg     <= gap_cnt_next;
            tx_word_reg     <= tx_word_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        payload_next     = payload_reg;
        offset_next      = offset_reg;
        repeat_next      = repeat_reg;
        word_idx_next    = word_idx_reg;
        frame_idx_next   = frame_idx_reg;
        frames_sent_next = frames_sent_reg;
        gap_cnt_next     = gap_cnt_reg;
        done_next        = 1'b0;
        load_word        = 1'b0;

        if (abort && state_reg != S_IDLE) begin
            // Everything else holds, including frames_sent.
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // abort in IDLE suppresses start.
                    if (start && !abort) begin
                        payload_next     = payload;
                        offset_next      = nonce_offset;
                        repeat_next      = repeat_count;
                        word_idx_next    = '0;
                        frame_idx_next   = '0;
                        frames_sent_next = '0;
                        load_word        = 1'b1;
                        state_next       = S_SEND;
                    end
                end
                S_SEND: state_next = S_ACK;
                // tx_busy only rises the cycle after tx_send, so it is not
                // trusted until DRAIN.
                S_ACK:  state_next = S_DRAIN;
                S_DRAIN: begin
                    if (!tx.tx_busy) begin
                        if (word_idx_reg != LAST_IDX) begin
                            word_idx_next = word_idx_reg + IDX_W'(1);
                            load_word     = 1'b1;
                            state_next    = S_SEND;
                        end else begin
                            frames_sent_next = frames_sent_reg + (REPEAT_WIDTH+1)'(1);
                            if (frame_idx_reg != repeat_reg) begin
                                if (GAP_CYCLES == 0) begin
                                    word_idx_next  = '0;
                                    frame_idx_next = frame_idx_reg + REPEAT_WIDTH'(1);
                                    load_word      = 1'b1;
                                    state_next     = S_SEND;
                                end else begin
                                    gap_cnt_next = GAP_W'(GAP_CYCLES);
                                    state_next   = S_GAP;
                                end
                            end else begin
                                done_next  = 1'b1;
                                state_next = S_IDLE;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // The counter is decremented each cycle and the next frame
                    // starts as it reaches zero, so GAP lasts GAP_CYCLES cycles.
                    if (gap_cnt_reg <= GAP_W'(1)) begin
                        gap_cnt_next   = '0;
                        word_idx_next  = '0;
                        frame_idx_next = frame_idx_reg + REPEAT_WIDTH'(1);
                        load_word      = 1'b1;
                        state_next     = S_SEND;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // tx_word is loaded on the edge that enters SEND so it is already valid
    // during the tx_send cycle; the nonce word gets offset + frame index.
    always_comb begin
        tx_word_next = tx_word_reg;
        if (load_word) begin
            tx_word_next = word_sel[word_idx_next];
            if (word_idx_next == NONCE_IDX) begin
                tx_word_next = word_sel[word_idx_next] + offset_next
                             + WORD_WIDTH'(frame_idx_next);
            end
        end
    end

    assign tx.tx_word  = tx_word_reg;
    assign tx.tx_send  = (state_reg == S_SEND) && !abort;
    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign frames_sent = frames_sent_reg;
endmodule

// File: tb/tb_getwork_streamer.sv
module tb_getwork_streamer;
    localparam int W  = 32;
    localparam int N  = 13;
    localparam int NI = 1;
    localparam int G  = 16;
    localparam int RW = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [N*W-1:0] payload = '0;
    logic [W-1:0]   nonce_offset = '0;
    logic [RW-1:0]  repeat_count = '0;
    logic           busy;
    logic           done;
    logic [RW:0]    frames_sent;

    getwork_streamer_if #(.WORD_WIDTH(W)) tx_if ();

    getwork_streamer #(
        .WORD_WIDTH(W), .NUM_WORDS(N), .NONCE_INDEX(NI),
        .GAP_CYCLES(G), .REPEAT_WIDTH(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .payload(payload),
        .nonce_offset(nonce_offset), .repeat_count(repeat_count), .abort(abort),
        .tx(tx_if), .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting one cycle after tx_send.
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (!reset_n)            busy_cnt <= 0;
        else if (tx_if.tx_send)  busy_cnt <= busy_len;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end
    assign tx_if.tx_busy = (busy_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    logic [W-1:0] obs_w[$];
    int           obs_c[$];
    int           done_c[$];
    int           done_busy_bad = 0;
    always @(negedge clk) begin
        if (tx_if.tx_send) begin
            obs_w.push_back(tx_if.tx_word);
            obs_c.push_back(cyc);
        end
        if (done) begin
            done_c.push_back(cyc);
            if (busy) done_busy_bad = done_busy_bad + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_in();
        @(posedge clk);
        #1;
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    logic [W-1:0] gen_w [N];

    function automatic logic [N*W-1:0] mk(input logic [W-1:0] nonce);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[(N-1-i)*W +: W] = (i == NI) ? nonce : gen_w[i];
        return p;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_word"}, 64'(tx_if.tx_word), 64'd0);
        chk({tag, "_tx_send"}, 64'(tx_if.tx_send), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_frames_sent"}, 64'(frames_sent), 64'd0);
    endtask

    // One complete transfer, checked against a word-list model built from the
    // frame rules: every frame repeats the payload, nonce word = nonce+off+frame.
    task automatic run(input logic [N*W-1:0] pl, input logic [W-1:0] off, input int rep,
                       input int blen, input bit poke, input string tag,
                       output logic [W-1:0] first_nonce, output logic [W-1:0] last_nonce);
        logic [W-1:0] ew[$];
        logic [W-1:0] w;
        int start_c, waited, step, last;
        bit poked;
        step = mx(3, blen + 2);
        for (int f = 0; f <= rep; f++)
            for (int i = 0; i < N; i++) begin
                w = pl[(N-1-i)*W +: W];
                if (i == NI) w = w + off + W'(f);
                ew.push_back(w);
            end
        first_nonce = ew[NI];
        last_nonce  = ew[rep*N + NI];

        clk_in();
        obs_w.delete(); obs_c.delete(); done_c.delete(); done_busy_bad = 0;
        busy_len = blen;
        payload = pl; nonce_offset = off; repeat_count = RW'(rep); start = 1'b1;
        start_c = cyc;
        clk_in();
        start = 1'b0; payload = ~pl; nonce_offset = ~off; repeat_count = ~RW'(rep);
        chk({tag, "_first_send"}, 64'(tx_if.tx_send), 64'd1);
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        chk({tag, "_first_word"}, 64'(tx_if.tx_word), 64'(ew[0]));

        waited = 0; poked = 1'b0;
        while (done_c.size() == 0 && waited < 5000) begin
            if (poke && !poked && obs_w.size() >= 5) begin
                start = 1'b1; poked = 1'b1;
            end
            clk_in();
            start = 1'b0;
            waited++;
        end
        chk({tag, "_timeout"}, 64'(waited < 5000), 64'd1);
        repeat (6) clk_in();

        chk({tag, "_send_count"}, 64'(obs_w.size()), 64'(ew.size()));
        for (int k = 0; k < obs_w.size() && k < ew.size(); k++)
            chk({tag, $sformatf("_word%0d", k)}, 64'(obs_w[k]), 64'(ew[k]));
        if (obs_c.size() > 0)
            chk({tag, "_send_latency"}, 64'(obs_c[0] - start_c), 64'd1);
        for (int k = 1; k < obs_c.size(); k++)
            chk({tag, $sformatf("_spacing%0d", k)}, 64'(obs_c[k] - obs_c[k-1]),
                64'(step + (((k % N) == 0) ? G : 0)));
        chk({tag, "_done_count"}, 64'(done_c.size()), 64'd1);
        last = obs_c.size() - 1;
        if (done_c.size() > 0 && last >= 0)
            chk({tag, "_done_time"}, 64'(done_c[0] - obs_c[last]), 64'(step));
        chk({tag, "_busy_at_done"}, 64'(done_busy_bad), 64'd0);
        chk({tag, "_frames_sent"}, 64'(frames_sent), 64'(rep + 1));
        chk({tag, "_word_held"}, 64'(tx_if.tx_word), 64'(ew[ew.size()-1]));
    endtask

    typedef struct {
        logic [W-1:0] nonce;
        logic [W-1:0] off;
        int           rep;
        int           blen;
        bit           poke;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_last;
        int           exp_frames;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [W-1:0] fn, ln;
        logic [N*W-1:0] rp;
        int waited;

        gen_w = '{32'h000007ff, 32'hffbd9207, 32'hffff001e, 32'h8b5f3f14, 32'h1fd9c0fc,
                  32'h4a5e1e4b, 32'haa1e9d52, 32'h12a83e0c, 32'h2e6b1f32, 32'h9d2e5a77,
                  32'h01d7c08a, 32'h5c3e9b10, 32'h00ea633b};
        tbl[0] = '{32'hffbd9207, 32'h00000000, 0, 5, 1'b0, 32'hffbd9207, 32'hffbd9207, 1};
        tbl[1] = '{32'hffbd9207, 32'hffffffff, 0, 0, 1'b0, 32'hffbd9206, 32'hffbd9206, 1};
        tbl[2] = '{32'hffbd9207, 32'hfffffffe, 2, 3, 1'b0, 32'hffbd9205, 32'hffbd9207, 3};
        tbl[3] = '{32'hffffffff, 32'h00000001, 1, 2, 1'b0, 32'h00000000, 32'h00000001, 2};
        tbl[4] = '{32'hffbd9207, 32'h00000000, 0, 2, 1'b1, 32'hffbd9207, 32'hffbd9207, 1};

        // Reset state
        reset_n = 1'b0;
        repeat (3) clk_in();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        clk_in();
        chk_reset_outputs("post_reset");

        // start together with abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        clk_in();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        chk("start_abort_send", 64'(tx_if.tx_send), 64'd0);

        // Table-driven directed transfers
        for (int t = 0; t < 5; t++) begin
            run(mk(tbl[t].nonce), tbl[t].off, tbl[t].rep, tbl[t].blen, tbl[t].poke,
                $sformatf("vec%0d", t), fn, ln);
            chk($sformatf("vec%0d_first_nonce", t), 64'(fn), 64'(tbl[t].exp_first));
            chk($sformatf("vec%0d_last_nonce", t), 64'(ln), 64'(tbl[t].exp_last));
            chk($sformatf("vec%0d_frames", t), 64'(frames_sent), 64'(tbl[t].exp_frames));
            if (obs_w.size() > 2) begin
                chk($sformatf("vec%0d_word0", t), 64'(obs_w[0]), 64'(gen_w[0]));
                chk($sformatf("vec%0d_word2", t), 64'(obs_w[2]), 64'(gen_w[2]));
            end
        end

        // Abort with the transmitter stuck busy
        clk_in();
        obs_w.delete(); obs_c.delete(); done_c.delete();
        busy_len = 100;
        payload = mk(32'hffbd9207); nonce_offset = '0; repeat_count = '0; start = 1'b1;
        clk_in();
        start = 1'b0;
        waited = 0;
        while (obs_w.size() < 5 && waited < 3000) begin
            clk_in();
            waited++;
        end
        chk("abort_wait", 64'(waited < 3000), 64'd1);
        abort = 1'b1;
        clk_in();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_send", 64'(tx_if.tx_send), 64'd0);
        repeat (150) clk_in();
        chk("abort_sends", 64'(obs_w.size()), 64'd5);
        chk("abort_no_done", 64'(done_c.size()), 64'd0);
        chk("abort_frames", 64'(frames_sent), 64'd0);
        run(mk(32'hffbd9207), 32'h0, 0, 0, 1'b0, "after_abort", fn, ln);

        // Reset during DRAIN of word 7
        clk_in();
        obs_w.delete(); obs_c.delete(); done_c.delete();
        busy_len = 20;
        payload = mk(32'hffbd9207); nonce_offset = '0; repeat_count = 8'd1; start = 1'b1;
        clk_in();
        start = 1'b0;
        waited = 0;
        while (obs_w.size() < 8 && waited < 3000) begin
            clk_in();
            waited++;
        end
        chk("rst_wait", 64'(waited < 3000), 64'd1);
        repeat (3) clk_in();
        reset_n = 1'b0;
        clk_in();
        chk_reset_outputs("mid_reset");
        reset_n = 1'b1;
        run(mk(32'hffbd9207), 32'h0, 0, 1, 1'b0, "after_reset", fn, ln);

        // Randomised transfers against the model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) rp[i*W +: W] = W'($urandom);
            run(rp, W'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'b0, $sformatf("rand%0d", r), fn, ln);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
